// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through buffer for 4-bit ALU results.
// Each entry holds {opcode, carry, zero, result}. Pushes arriving while the
// buffer is full are discarded and tallied in a saturating drop counter.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [3:0]    in_result,
    input  logic          in_carry,
    input  logic          in_zero,
    input  logic [2:0]    in_opcode,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_result,
    output logic          out_carry,
    output logic          out_zero,
    output logic [2:0]    out_opcode,
    output logic [AW:0]   count,
    output logic [7:0]    drop_count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    logic [8:0]    head;

    // Handshake decode; full/empty come from the occupancy count only.
    always_comb begin
        in_ready  = (count != FULL_COUNT);
        out_valid = (count != '0);
        push      = in_valid & in_ready;
        drop      = in_valid & ~in_ready;
        pop       = out_valid & out_ready;
    end

    // Storage write; contents are not reset and are hidden while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_opcode, in_carry, in_zero, in_result};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // Saturating tally of rejected pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // Head entry, forced to zero when nothing is buffered.
    always_comb begin
        head       = out_valid ? mem[rd_ptr] : 9'd0;
        out_result = head[3:0];
        out_zero   = head[4];
        out_carry  = head[5];
        out_opcode = head[8:6];
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed stimulus, queue-based reference model checked
// every cycle, plus literal expectations at key points.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [3:0]    in_result;
    logic          in_carry;
    logic          in_zero;
    logic [2:0]    in_opcode;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_result;
    logic          out_carry;
    logic          out_zero;
    logic [2:0]    out_opcode;
    logic [AW:0]   count;
    logic [7:0]    drop_count;

    int total = 0;
    int bad   = 0;

    alu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_zero    (in_zero),
        .in_opcode  (in_opcode),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_opcode (out_opcode),
        .count      (count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of packed entries and a drop tally.
    logic [8:0] mq[$];
    int         mdrops;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mdrops = 0;
        end else begin
            automatic bit room = (mq.size() < DEPTH);
            automatic bit take = out_ready && (mq.size() > 0);
            if (take) void'(mq.pop_front());
            if (in_valid && room) mq.push_back({in_opcode, in_carry, in_zero, in_result});
            if (in_valid && !room && mdrops < 255) mdrops++;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        automatic logic [8:0] h = (mq.size() > 0) ? mq[0] : 9'd0;
        check("m_in_ready",  32'(in_ready),   32'(mq.size() != DEPTH));
        check("m_out_valid", 32'(out_valid),  32'(mq.size() != 0));
        check("m_count",     32'(count),      32'(mq.size()));
        check("m_drops",     32'(drop_count), 32'(mdrops));
        check("m_head",      32'({out_opcode, out_carry, out_zero, out_result}), 32'(h));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [3:0] r, input bit c, input bit z,
                          input logic [2:0] op);
        in_valid  = v;
        in_result = r;
        in_carry  = c;
        in_zero   = z;
        in_opcode = op;
    endtask

    task automatic push(input logic [3:0] r);
        set_in(1'b1, r, r[0], (r == 4'd0), r[2:0]);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Idle after reset.
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);

        // Single push then pop.
        set_in(1'b1, 4'h5, 1'b1, 1'b0, 3'b010);
        step();
        in_valid = 1'b0;
        check("p1_valid", 32'(out_valid), 32'd1);
        check("p1_result", 32'(out_result), 32'h5);
        check("p1_carry", 32'(out_carry), 32'd1);
        check("p1_opcode", 32'(out_opcode), 32'd2);
        check("p1_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop1_valid", 32'(out_valid), 32'd0);
        check("pop1_result", 32'(out_result), 32'd0);
        check("pop1_carry", 32'(out_carry), 32'd0);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 4; i++) push(4'(i));
        push(4'h9);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);
        check("full_drops", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_head", 32'(out_result), 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);

        // Full with push and pop together: pop wins, push dropped.
        for (int i = 10; i <= 13; i++) push(4'(i));
        set_in(1'b1, 4'hE, 1'b0, 1'b0, 3'd7);
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fpp_count", 32'(count), 32'd3);
        check("fpp_drops", 32'(drop_count), 32'd2);
        check("fpp_head", 32'(out_result), 32'hB);

        // Down to two entries (C, D), then stream 0..9 through.
        out_ready = 1'b1;
        step();
        check("pre_count", 32'(count), 32'd2);
        for (int i = 0; i < 10; i++) begin
            automatic int exp_head = (i == 0) ? 12 : (i == 1) ? 13 : i - 2;
            check("stream_head", 32'(out_result), 32'(exp_head));
            set_in(1'b1, 4'(i), 1'b0, 1'b0, 3'd1);
            step();
            check("stream_count", 32'(count), 32'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("post_stream_head", 32'(out_result), 32'd8);

        // Fill and force 300 drops to hit saturation.
        push(4'd10);
        push(4'd11);
        set_in(1'b1, 4'hF, 1'b1, 1'b1, 3'd5);
        repeat (300) step();
        in_valid = 1'b0;
        check("sat_drops", 32'(drop_count), 32'd255);
        check("sat_count", 32'(count), 32'd4);

        // Async reset with three entries buffered.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_drops", 32'(drop_count), 32'd0);
        step();
        rst = 1'b0;
        push(4'h6);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_head", 32'(out_result), 32'h6);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
